// File: rtl/regfile_pkg.sv
// Shared widths, types and reset value for the 16x16 register file.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_data_t RESET_VALUE = 16'h0000;

endpackage

// File: rtl/reg_file_16x16_reg_word.sv
// One DATA_W-bit storage word with synchronous active-high reset and load enable.
module reg_word
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      ld,
    input  reg_data_t d,
    output reg_data_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_16x16.sv
// 16x16 register file: two combinational read ports, one synchronous write port.
// Define REGFILE_ZERO_REG_EN to hard-wire register 0 to zero (no storage for it).
module reg_file_16x16
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t Rs,
    input  reg_addr_t Rt,
    input  reg_addr_t Rd,
    input  reg_data_t RW,
    input  logic      wr,
    output reg_data_t Rout1,
    output reg_data_t Rout2
);

    logic [NUM_REGS-1:0] ld_onehot;
    reg_data_t           regs [NUM_REGS];

    always_comb begin
        ld_onehot = '0;
        if (wr) begin
            ld_onehot[Rd] = 1'b1;
        end
    end

`ifdef REGFILE_ZERO_REG_EN
    localparam int FIRST_REG = 1;
    assign regs[0] = RESET_VALUE;
`else
    localparam int FIRST_REG = 0;
`endif

    generate
        for (genvar i = FIRST_REG; i < NUM_REGS; i++) begin : g_word
            reg_word u_word (
                .clk (clk),
                .rst (rst),
                .ld  (ld_onehot[i]),
                .d   (RW),
                .q   (regs[i])
            );
        end
    endgenerate

    // No write bypass: reads see the array only.
    assign Rout1 = regs[Rs];
    assign Rout2 = regs[Rt];

endmodule

// File: tb/tb_reg_file_16x16.sv
// Scoreboard bench for reg_file_16x16; expectations follow REGFILE_ZERO_REG_EN when defined.
module tb_reg_file_16x16;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    reg_addr_t Rs, Rt, Rd;
    reg_data_t RW;
    logic      wr;
    reg_data_t Rout1, Rout2;

    typedef struct {
        string     name;
        reg_data_t exp1;
        reg_data_t exp2;
    } exp_t;

    exp_t q_exp[$];
    int   checks   = 0;
    int   failures = 0;

    reg_file_16x16 dut (
        .clk   (clk),
        .rst   (rst),
        .Rs    (Rs),
        .Rt    (Rt),
        .Rd    (Rd),
        .RW    (RW),
        .wr    (wr),
        .Rout1 (Rout1),
        .Rout2 (Rout2)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are settled at the falling edge, mid-cycle.
    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            exp_t e;
            e = q_exp.pop_front();
            checks++;
            if (Rout1 !== e.exp1 || Rout2 !== e.exp2) begin
                failures++;
                $display("FAIL %s: Rs=%0d Rt=%0d got Rout1=%h Rout2=%h expected Rout1=%h Rout2=%h",
                         e.name, Rs, Rt, Rout1, Rout2, e.exp1, e.exp2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string name, input reg_addr_t rs, input reg_addr_t rt,
                             input reg_data_t e1, input reg_data_t e2);
        exp_t e;
        Rs = rs;
        Rt = rt;
        e.name = name;
        e.exp1 = e1;
        e.exp2 = e2;
        q_exp.push_back(e);
        @(negedge clk);
        #1;
    endtask

    reg_data_t zero_exp;

    initial begin
        rst = 1'b1; wr = 1'b1; Rd = 4'd3; RW = 16'hFFFF; Rs = '0; Rt = '0;
        tick();
        tick();
        rst = 1'b0; wr = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            expect_rd("reset_sweep", reg_addr_t'(i), reg_addr_t'(NUM_REGS-1-i), 16'h0000, 16'h0000);
        end

        tick();
        wr = 1'b1; Rd = 4'd1; RW = 16'h03E8;
        tick();
        Rd = 4'd4; RW = 16'h05DC;
        tick();
        wr = 1'b0;
        expect_rd("write_read", 4'd1, 4'd4, 16'h03E8, 16'h05DC);

        tick();
        wr = 1'b0; Rd = 4'd1; RW = 16'h07D0;
        tick();
        expect_rd("wr_low", 4'd1, 4'd1, 16'h03E8, 16'h03E8);

        tick();
        wr = 1'b1; Rd = 4'd6; RW = 16'h09C4;
        expect_rd("no_bypass_1", 4'd6, 4'd6, 16'h0000, 16'h0000);
        tick();
        RW = 16'h0BB8;
        expect_rd("first_write", 4'd6, 4'd6, 16'h09C4, 16'h09C4);
        tick();
        wr = 1'b0;
        expect_rd("overwrite", 4'd6, 4'd6, 16'h0BB8, 16'h0BB8);

        tick();
        wr = 1'b1; Rd = 4'd8; RW = 16'h0DAC;
        tick();
        wr = 1'b0;
        expect_rd("load_r8", 4'd8, 4'd1, 16'h0DAC, 16'h03E8);
        tick();
        rst = 1'b1; wr = 1'b1; Rd = 4'd8; RW = 16'h1234;
        tick();
        rst = 1'b0; wr = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            expect_rd("reset_over_write", reg_addr_t'(i), reg_addr_t'((i + 8) % NUM_REGS),
                      16'h0000, 16'h0000);
        end

        tick();
`ifdef REGFILE_ZERO_REG_EN
        zero_exp = 16'h0000;
`else
        zero_exp = 16'hBEEF;
`endif
        wr = 1'b1; Rd = 4'd0; RW = 16'hBEEF;
        tick();
        Rd = 4'd5; RW = 16'h5A5A;
        tick();
        wr = 1'b0;
        expect_rd("zero_reg", 4'd0, 4'd5, zero_exp, 16'h5A5A);
        expect_rd("zero_reg_rt", 4'd5, 4'd0, 16'h5A5A, zero_exp);

        for (int n = 0; n < 20 && q_exp.size() > 0; n++) begin
            @(negedge clk);
        end
        if (q_exp.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
